iq_byte_packer: RTL
===================

// Module: iq_byte_packer
// PURPOSE
// - Inverse of the IQ byte reader: pops one quantized I sample and one quantized Q sample per pair, dequantizes each to signed 16 bits and serializes the pair into a byte FIFO.
// - Byte order per pair: I[7:0], I[15:8], Q[7:0], Q[15:8] (little-endian, I first).
// - Sits at the tail of an IQ datapath to produce raw interleaved 16-bit IQ byte streams for file dump or loopback into the reader.
// PARAMETERS
// - DATA_SIZE  32  width of the quantized I/Q input words (signed)
// - BYTE_SIZE  8   output byte width
// - CHAR_SIZE  16  width of a dequantized sample (signed)
// - BITS       10  fractional bits removed by dequantization
// PORTS
// - clock      in   1          clock
// - reset      in   1          reset, asynchronous, active-high
// - i_in       in   DATA_SIZE  head of I FIFO (first-word fall-through, valid when !i_empty)
// - i_empty    in   1          I FIFO empty
// - i_rd_en    out  1          pop I FIFO
// - q_in       in   DATA_SIZE  head of Q FIFO (first-word fall-through)
// - q_empty    in   1          Q FIFO empty
// - q_rd_en    out  1          pop Q FIFO
// - out_full   in   1          byte FIFO full
// - out_wr_en  out  1          push data_out into byte FIFO
// - data_out   out  BYTE_SIZE  byte to push; valid only when out_wr_en=1
// - sat_count  out  16         number of samples clipped since reset; wraps at 2^16
// BEHAVIOUR
// - Reset (async): state=IDLE, holding regs i_hold=q_hold=0, sat_count=0; i_rd_en=q_rd_en=out_wr_en=0, data_out=0.
// - Enables and data_out are combinational from state and flags; everything else is registered.
// - Dequantization per sample: s = val >>> BITS (arithmetic, truncates toward -inf). Clip s to [-32768, 32767] and keep the low CHAR_SIZE bits.
// - sat_count increments by (I clipped) + (Q clipped) in the cycle a pair is popped.
// - Pop rule: i_rd_en and q_rd_en are always asserted together, and only when i_empty=0 and q_empty=0. A lone non-empty FIFO is never popped.
// - A pop loads i_hold and q_hold with the dequantized values on the next edge.
// - IDLE: if both FIFOs are non-empty, pop and go to WR_I_LO; otherwise stay in IDLE.
// - WR_I_LO / WR_I_HI / WR_Q_LO: if out_full=0, assert out_wr_en with the matching byte (i_hold[7:0], i_hold[15:8], q_hold[7:0]) and advance. If out_full=1, hold the state with out_wr_en=0.
// - WR_Q_HI: if out_full=0, assert out_wr_en with q_hold[15:8]. In the same cycle, if both FIFOs are non-empty, also pop and go to WR_I_LO (pop-ahead); otherwise go to IDLE. If out_full=1, hold the state with no write and no pop.
// - Throughput: 4 cycles per pair when streaming. First byte appears 1 cycle after the IDLE pop.
// - Backpressure never drops or duplicates a byte. The holding regs change only on a pop.
// - Invalid state encoding: go to IDLE, drive all enables 0.
// - Reset mid-pair discards the partial pair. The FIFO words already popped are not replayed.
// TESTING
// - i_in=0x00000400, q_in=0xFFFFFC00, out never full -> bytes 01 00 FF FF; sat_count=0.
// - i_in=0x7FFFFFFF, q_in=0x80000000 -> bytes FF 7F 00 80; sat_count=2.
// - i_in=0xFFFFFFFF (-1), q_in=0x000003FF -> bytes FF FF 00 00 (truncation toward -inf).
// - out_full high for 3 cycles during WR_I_HI -> no writes while full, state held, final sequence identical to the unstalled case.
// - Both FIFOs hold 8 pairs, out_full=0 -> out_wr_en continuously high for 32 cycles after the first pop, no IDLE cycles in between.
// - I non-empty, Q empty for 10 cycles -> no rd_en asserted; reset asserted in WR_Q_LO -> outputs 0, state IDLE, no spurious write.

Source files
------------

// File: rtl/iq_byte_packer.sv
// iq_byte_packer: pops one quantized I/Q pair, dequantizes each sample to signed
// CHAR_SIZE bits with saturation, and writes the pair out as four little-endian
// bytes in the order I[7:0], I[15:8], Q[7:0], Q[15:8].
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   i_in, i_empty, i_rd_en  first-word-fall-through I FIFO head, empty flag, pop
//   q_in, q_empty, q_rd_en  first-word-fall-through Q FIFO head, empty flag, pop
//   out_full, out_wr_en     byte FIFO full flag and push strobe
//   data_out                byte pushed when out_wr_en=1, otherwise 0
//   sat_count               samples clipped since reset, wraps at 2^16
module iq_byte_packer #(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int CHAR_SIZE = 16,
    parameter int BITS      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] i_in,
    input  logic                 i_empty,
    output logic                 i_rd_en,
    input  logic [DATA_SIZE-1:0] q_in,
    input  logic                 q_empty,
    output logic                 q_rd_en,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [BYTE_SIZE-1:0] data_out,
    output logic [15:0]          sat_count
);
    typedef enum logic [2:0] {IDLE, WR_I_LO, WR_I_HI, WR_Q_LO, WR_Q_HI} state_t;

    localparam logic [CHAR_SIZE-1:0] POS_MAX = {1'b0, {(CHAR_SIZE-1){1'b1}}};
    localparam logic [CHAR_SIZE-1:0] NEG_MIN = {1'b1, {(CHAR_SIZE-1){1'b0}}};

    state_t                      state;
    logic [CHAR_SIZE-1:0]        i_hold, q_hold, i_deq, q_deq;
    logic signed [DATA_SIZE-1:0] i_s, q_s;
    logic                        i_clip, q_clip, both, pop, writing;

    assign i_s = $signed(i_in) >>> BITS;
    assign q_s = $signed(q_in) >>> BITS;

    // A shifted sample fits in CHAR_SIZE bits only when every bit from the
    // CHAR_SIZE-1 position upward is a copy of the sign bit.
    assign i_clip = i_s[DATA_SIZE-1:CHAR_SIZE-1] != {(DATA_SIZE-CHAR_SIZE+1){i_s[DATA_SIZE-1]}};
    assign q_clip = q_s[DATA_SIZE-1:CHAR_SIZE-1] != {(DATA_SIZE-CHAR_SIZE+1){q_s[DATA_SIZE-1]}};
    assign i_deq  = !i_clip ? i_s[CHAR_SIZE-1:0] : i_s[DATA_SIZE-1] ? NEG_MIN : POS_MAX;
    assign q_deq  = !q_clip ? q_s[CHAR_SIZE-1:0] : q_s[DATA_SIZE-1] ? NEG_MIN : POS_MAX;

    assign both    = !i_empty && !q_empty;
    // Enables are gated by reset so nothing is popped or pushed while held in reset.
    assign writing = !reset && !out_full &&
                     (state == WR_I_LO || state == WR_I_HI || state == WR_Q_LO || state == WR_Q_HI);
    // WR_Q_HI pops the next pair in the same cycle as its last byte to keep 4 cycles per pair.
    assign pop     = !reset && both && (state == IDLE || (state == WR_Q_HI && !out_full));

    assign i_rd_en   = pop;
    assign q_rd_en   = pop;
    assign out_wr_en = writing;
    assign data_out  = !writing          ? '0 :
                       state == WR_I_LO ? i_hold[BYTE_SIZE-1:0] :
                       state == WR_I_HI ? i_hold[2*BYTE_SIZE-1:BYTE_SIZE] :
                       state == WR_Q_LO ? q_hold[BYTE_SIZE-1:0] :
                                          q_hold[2*BYTE_SIZE-1:BYTE_SIZE];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i_hold    <= '0;
            q_hold    <= '0;
            sat_count <= '0;
        end else begin
            if (pop) begin
                i_hold    <= i_deq;
                q_hold    <= q_deq;
                sat_count <= sat_count + {15'd0, i_clip} + {15'd0, q_clip};
            end
            case (state)
                IDLE:    state <= both ? WR_I_LO : IDLE;
                WR_I_LO: state <= out_full ? WR_I_LO : WR_I_HI;
                WR_I_HI: state <= out_full ? WR_I_HI : WR_Q_LO;
                WR_Q_LO: state <= out_full ? WR_Q_LO : WR_Q_HI;
                WR_Q_HI: state <= out_full ? WR_Q_HI : both ? WR_I_LO : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
